// File: rtl/mvm_stream_pipe_if.sv
// rtl/mvm_stream_pipe_if.sv - operand and result stream bundle for mvm_stream_pipe
interface mvm_stream_pipe_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_data;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             m_last;

  // Environment side: supplies operands, consumes results
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  // Multiplier side: accepts operands, produces results
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/mvm_stream_pipe.sv
// rtl/mvm_stream_pipe.sv - streaming signed matrix-vector multiplier with ping-pong operand banks
// Build option MVM_SATURATE_EN: clamp results to the OUT_W signed range instead of wrapping.
module mvm_stream_pipe #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input logic              clk,
  input logic              reset,
  mvm_stream_pipe_if.slave bus
);
  localparam int FRAME = ROWS * COLS + COLS;
  localparam int IW    = $clog2(FRAME);
  localparam int ACC_W = 2 * IN_W + $clog2(COLS);
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  localparam logic [IW-1:0] LD_LAST = IW'(FRAME - 1);
  localparam logic [IW-1:0] X_BASE  = IW'(ROWS * COLS);
  localparam logic [IW-1:0] C_LAST  = IW'(COLS - 1);
  localparam logic [IW-1:0] R_LAST  = IW'(ROWS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Two banks, each holding A row-major followed by x
  logic signed [IN_W-1:0]  mem [2][FRAME];

  logic [IW-1:0]           ld_cnt;
  logic                    fill_ptr;
  logic                    comp_ptr;
  logic [1:0]              full;
  logic [1:0]              state;
  logic [IW-1:0]           row;
  logic [IW-1:0]           col;
  logic [IW-1:0]           a_idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [2*IN_W-1:0] prod;
  logic signed [EXT_W-1:0] acc_ext;
  logic [OUT_W-1:0]        result;
  logic                    m_valid_q;
  logic                    m_last_q;
  logic [OUT_W-1:0]        m_data_q;
  logic                    s_fire;
  logic                    ld_done;
  logic                    out_free;
  logic                    emit;
  logic                    frame_done;

  assign bus.s_ready = !full[fill_ptr];
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;

  assign s_fire     = bus.s_valid && !full[fill_ptr];
  assign ld_done    = s_fire && (ld_cnt == LD_LAST);
  assign out_free   = !m_valid_q || bus.m_ready;
  assign emit       = (state == ST_HOLD) && out_free;
  assign frame_done = emit && (row == R_LAST);

  assign prod    = mem[comp_ptr][a_idx] * mem[comp_ptr][X_BASE + col];
  assign acc_ext = EXT_W'(acc);

  // First column of each row starts a fresh sum
  always_comb begin
    acc_base = acc;
    if (col == '0) acc_base = '0;
  end

`ifdef MVM_SATURATE_EN
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Clamp the wide sum into the signed output range
  always_comb begin
    result = OUT_W'(acc_ext);
    if (acc_ext > SAT_MAX)      result = OUT_W'(SAT_MAX);
    else if (acc_ext < SAT_MIN) result = OUT_W'(SAT_MIN);
  end
`else
  // Keep the low OUT_W bits (two's-complement wrap)
  always_comb begin
    result = OUT_W'(acc_ext);
  end
`endif

  // Operand storage: write the accepted word into the fill bank
  always_ff @(posedge clk) begin
    if (s_fire) mem[fill_ptr][ld_cnt] <= bus.s_data;
  end

  // Load counter walks one frame, then hands the bank to the engine
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_cnt   <= '0;
      fill_ptr <= 1'b0;
    end else if (s_fire) begin
      if (ld_cnt == LD_LAST) begin
        ld_cnt   <= '0;
        fill_ptr <= !fill_ptr;
      end else begin
        ld_cnt <= ld_cnt + IW'(1);
      end
    end
  end

  // Bank occupancy: filled bank and released bank are always different, so both may update together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= '0;
    end else begin
      if (ld_done)    full[fill_ptr] <= 1'b1;
      if (frame_done) full[comp_ptr] <= 1'b0;
    end
  end

  // Engine: one row at a time, COLS MAC cycles then a hand-off cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      row      <= '0;
      col      <= '0;
      a_idx    <= '0;
      acc      <= '0;
      comp_ptr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (full[comp_ptr]) begin
            state <= ST_MAC;
            row   <= '0;
            col   <= '0;
            a_idx <= '0;
          end
        end
        ST_MAC: begin
          acc   <= acc_base + ACC_W'(prod);
          a_idx <= a_idx + IW'(1);
          if (col == C_LAST) begin
            col   <= '0;
            state <= ST_HOLD;
          end else begin
            col <= col + IW'(1);
          end
        end
        ST_HOLD: begin
          if (out_free) begin
            if (row == R_LAST) begin
              state    <= ST_IDLE;
              comp_ptr <= !comp_ptr;
            end else begin
              row   <= row + IW'(1);
              state <= ST_MAC;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result register: overwritten by a new row result, otherwise emptied by the consumer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (emit) begin
      m_valid_q <= 1'b1;
      m_data_q  <= result;
      m_last_q  <= (row == R_LAST);
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mvm_stream_pipe.sv
// tb/tb_mvm_stream_pipe.sv - randomized self-checking bench for mvm_stream_pipe against a frame-level model
module tb_mvm_stream_pipe;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 16;
  localparam int ROWS_A = 4;
  localparam int COLS_A = 4;
  localparam int ROWS_B = 3;
  localparam int COLS_B = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Edge counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  logic        sv [2];
  logic [7:0]  sd [2];
  logic        mr [2];
  logic        sr [2];
  logic        mv [2];
  logic        ml [2];
  logic [15:0] md [2];

  mvm_stream_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus_a ();
  mvm_stream_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus_b ();

  assign bus_a.s_valid = sv[0];
  assign bus_a.s_data  = sd[0];
  assign bus_a.m_ready = mr[0];
  assign sr[0]         = bus_a.s_ready;
  assign mv[0]         = bus_a.m_valid;
  assign md[0]         = bus_a.m_data;
  assign ml[0]         = bus_a.m_last;

  assign bus_b.s_valid = sv[1];
  assign bus_b.s_data  = sd[1];
  assign bus_b.m_ready = mr[1];
  assign sr[1]         = bus_b.s_ready;
  assign mv[1]         = bus_b.m_valid;
  assign md[1]         = bus_b.m_data;
  assign ml[1]         = bus_b.m_last;

  mvm_stream_pipe #(.ROWS(ROWS_A), .COLS(COLS_A), .IN_W(IN_W), .OUT_W(OUT_W)) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_a)
  );

  mvm_stream_pipe #(.ROWS(ROWS_B), .COLS(COLS_B), .IN_W(IN_W), .OUT_W(OUT_W)) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_b)
  );

  logic [7:0]  in_q   [$];
  logic [15:0] exp_q  [$];
  logic        last_q [$];

  int n_checks = 0;
  int n_err    = 0;
  int first_mv;
  int last_acc;
  int max_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int rows_of(input int k);
    return (k == 0) ? ROWS_A : ROWS_B;
  endfunction

  function automatic int cols_of(input int k);
    return (k == 0) ? COLS_A : COLS_B;
  endfunction

  function automatic logic [15:0] reduce(input longint sum);
`ifdef MVM_SATURATE_EN
    if (sum > 32767)  return 16'h7fff;
    if (sum < -32768) return 16'h8000;
`endif
    return 16'(sum);
  endfunction

  // kind: 0 random, 1 identity with x=1..COLS, 2 all 127, 3 A=-128 and x=127
  task automatic gen_frame(input int k, input int kind);
    int     r = rows_of(k);
    int     c = cols_of(k);
    int     a [32];
    int     x [8];
    longint sum;
    for (int i = 0; i < r * c; i++) begin
      case (kind)
        1:       a[i] = ((i / c) == (i % c)) ? 1 : 0;
        2:       a[i] = 127;
        3:       a[i] = -128;
        default: a[i] = int'($urandom_range(255)) - 128;
      endcase
      in_q.push_back(8'(a[i]));
    end
    for (int j = 0; j < c; j++) begin
      case (kind)
        1:       x[j] = j + 1;
        2, 3:    x[j] = 127;
        default: x[j] = int'($urandom_range(255)) - 128;
      endcase
      in_q.push_back(8'(x[j]));
    end
    for (int i = 0; i < r; i++) begin
      sum = 0;
      for (int j = 0; j < c; j++) sum += longint'(a[i * c + j]) * longint'(x[j]);
      exp_q.push_back(reduce(sum));
      last_q.push_back(i == r - 1);
    end
  endtask

  task automatic produce(input int k, input int p_valid, input int budget);
    logic acc;
    int   n = 0;
    int   stall = 0;
    max_stall = 0;
    while (in_q.size() > 0) begin
      @(negedge clk);
      acc = sv[k] && sr[k];
      if (!sr[k]) stall++;
      else        stall = 0;
      if (stall > max_stall) max_stall = stall;
      if (acc) last_acc = cyc + 1;
      @(posedge clk);
      #1;
      if (acc) void'(in_q.pop_front());
      if (in_q.size() > 0) begin
        sv[k] = ($urandom_range(99) < p_valid);
        sd[k] = in_q[0];
      end else begin
        sv[k] = 1'b0;
      end
      n++;
      if (n > budget) begin
        check("produce_timeout", 1, 0);
        in_q.delete();
        sv[k] = 1'b0;
      end
    end
  endtask

  task automatic consume(input int k, input int p_ready, input int budget);
    logic        held_v = 1'b0;
    logic [16:0] held = '0;
    int          n = 0;
    first_mv = -1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (mv[k] && first_mv < 0) first_mv = cyc;
      if (held_v) check("hold_stable", {mv[k], ml[k], md[k]}, {1'b1, held});
      if (mv[k] && mr[k]) begin
        check("y_data", md[k], exp_q.pop_front());
        check("y_last", ml[k], last_q.pop_front());
      end
      held_v = mv[k] && !mr[k];
      held   = {ml[k], md[k]};
      @(posedge clk);
      #1;
      mr[k] = ($urandom_range(99) < p_ready);
      n++;
      if (n > budget) begin
        check("consume_timeout", 1, 0);
        exp_q.delete();
        last_q.delete();
      end
    end
    mr[k] = 1'b0;
  endtask

  task automatic drained(input int k);
    repeat (4) @(negedge clk);
    check("drained_mvalid", mv[k], 0);
    check("drained_sready", sr[k], 1);
  endtask

  task automatic run_phase(input int k, input int p_valid, input int p_ready, input int budget);
    mr[k] = (p_ready >= 100);
    fork
      produce(k, p_valid, budget);
      consume(k, p_ready, budget);
    join
    drained(k);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b0;
      sd[k] = '0;
      mr[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_sready", sr[k], 1);
      check("reset_mvalid", mv[k], 0);
      check("reset_mdata",  md[k], 0);
      check("reset_mlast",  ml[k], 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Identity matrix and first-result latency
    gen_frame(0, 1);
    run_phase(0, 100, 100, 500);
    check("latency", first_mv - last_acc, COLS_A + 2);

    // Overflow behaviour at both extremes
    gen_frame(0, 2);
    gen_frame(0, 3);
    run_phase(0, 100, 100, 1000);

    // Backpressure: three frames against a stalled consumer
    repeat (3) gen_frame(0, 0);
    mr[0] = 1'b0;
    fork
      produce(0, 100, 5000);
      begin
        repeat (200) @(negedge clk);
        check("bp_sready",  sr[0], 0);
        check("bp_mvalid",  mv[0], 1);
        check("bp_mdata",   md[0], exp_q[0]);
        check("bp_mlast",   ml[0], 0);
        check("bp_pending", in_q.size(), ROWS_A * COLS_A + COLS_A);
        consume(0, 100, 5000);
      end
    join
    drained(0);

    // Reset with a result held and a partial frame loaded
    gen_frame(0, 0);
    for (int i = 0; i < 10; i++) in_q.push_back(8'($urandom_range(255)));
    mr[0] = 1'b0;
    produce(0, 100, 200);
    repeat (5) @(negedge clk);
    check("pre_rst_mvalid", mv[0], 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    last_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_mvalid", mv[0], 0);
      check("rst_sready", sr[0], 1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_sready", sr[0], 1);
    gen_frame(0, 0);
    run_phase(0, 60, 70, 1000);

    // Non-square instance with random gaps on both sides
    for (int f = 0; f < 200; f++) gen_frame(1, 0);
    run_phase(1, 70, 60, 200 * 120);

    // Back-to-back streaming, bounded ping-pong stall
    for (int f = 0; f < 1000; f++) gen_frame(0, 0);
    run_phase(0, 100, 100, 1000 * 40);
    check("pingpong_stall", max_stall <= ROWS_A * (COLS_A + 1) + 1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
